// File: rtl/halloween_effect_exec.sv
// Opcode executor for the decoration controller: owns power state, lamp colour,
// timed sound/movement/fog effects and the sequencer back-pressure handshake.
//
// state   | meaning
// S_OFF   | unpowered; only ON is accepted, everything else is discarded
// S_IDLE  | powered, ready for the next opcode
// S_SOUND | sound playing, timer running, upstream stalled
// S_MOVE  | hand-wave or jaw actuator running, upstream stalled
// S_FOG   | fog machine running, upstream stalled
module halloween_effect_exec #(
  parameter int unsigned SOUND_CYCLES = 8,
  parameter int unsigned MOVE_CYCLES  = 4,
  parameter int unsigned FOG_CYCLES   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [3:0] op,
  output logic       op_ready,
  output logic       sys_on,
  output logic [1:0] color,
  output logic       sound_active,
  output logic [1:0] sound_id,
  output logic       wave_hands,
  output logic       move_jaw,
  output logic       fog_on,
  output logic       eff_done,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {S_OFF, S_IDLE, S_SOUND, S_MOVE, S_FOG} state_t;

  localparam logic [7:0] SOUND_LD = 8'(SOUND_CYCLES - 1);
  localparam logic [7:0] MOVE_LD  = 8'(MOVE_CYCLES - 1);
  localparam logic [7:0] FOG_LD   = 8'(FOG_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] color_q, color_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] err_q, err_d;
  logic       done_q, done_d;
  logic       accept, err_inc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_OFF;
      timer_q <= 8'd0;
      color_q <= 2'd0;
      sel_q   <= 2'd0;
      err_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      color_q <= color_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign op_ready = (state_q == S_OFF) || (state_q == S_IDLE);
  assign accept   = op_valid && op_ready;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    color_d = color_q;
    sel_d   = sel_q;
    err_d   = err_q;
    done_d  = 1'b0;
    err_inc = 1'b0;
    case (state_q)
      S_OFF: begin
        if (accept) begin
          if (op == 4'b0000) state_d = S_IDLE;
          else               err_inc = 1'b1;
        end
      end
      S_IDLE: begin
        if (accept) begin
          case (op)
            4'b0000: ;
            4'b0001: begin
              state_d = S_OFF;
              color_d = 2'd0;
            end
            4'b0100, 4'b0101, 4'b0110: color_d = op[1:0] + 2'd1;
            4'b1000, 4'b1001, 4'b1010: begin
              state_d = S_SOUND;
              sel_d   = op[1:0];
              timer_d = SOUND_LD;
            end
            4'b1100, 4'b1101: begin
              state_d = S_MOVE;
              sel_d   = op[1:0];
              timer_d = MOVE_LD;
            end
            4'b1110: begin
              state_d = S_FOG;
              timer_d = FOG_LD;
            end
            default: err_inc = 1'b1;
          endcase
        end
      end
      S_SOUND, S_MOVE, S_FOG: begin
        // timer reaching zero marks the last active cycle of the effect
        if (timer_q == 8'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = S_OFF;
    endcase
    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  // sel_q doubles as the sound id and the actuator select (00 wave, 01 jaw)
  assign sys_on       = (state_q != S_OFF);
  assign color        = color_q;
  assign sound_active = (state_q == S_SOUND);
  assign sound_id     = (state_q == S_SOUND) ? sel_q : 2'd0;
  assign wave_hands   = (state_q == S_MOVE) && !sel_q[0];
  assign move_jaw     = (state_q == S_MOVE) && sel_q[0];
  assign fog_on       = (state_q == S_FOG);
  assign eff_done     = done_q;
  assign err_cnt      = err_q;

endmodule

// File: doc/halloween_effect_exec.md
Name: halloween_effect_exec

Overview:
- Consumer end of the decoration opcode stream: takes the 4-bit opcodes the channel sequencer emits and executes them.
- Drives the lamp colour, sound playback, animatronic movement and fog outputs.
- Owns system power state (ON/RESET) and per-effect duration timers.
- Applies back-pressure to the sequencer with a valid/ready handshake while a timed effect runs.

Parameters:
- SOUND_CYCLES, 8, cycles sound_active stays high per sound opcode (legal 1..255)
- MOVE_CYCLES, 4, cycles wave_hands/move_jaw stays high per movement opcode (legal 1..255)
- FOG_CYCLES, 12, cycles fog_on stays high per FOG opcode (legal 1..255)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, synchronous, active-low (rst==0 at posedge clk resets block)
- op_valid  input  1  upstream presents an opcode on op
- op  input  4  opcode, [3:2]=category (00 system, 01 colour, 10 sound, 11 movement/effect), [1:0]=command
- op_ready  output  1  block can accept; transfer occurs on posedge when op_valid && op_ready
- sys_on  output  1  decoration powered
- color  output  2  00 off, 01 green, 10 purple, 11 orange
- sound_active  output  1  sound playing
- sound_id  output  2  00 screaming, 01 cackling, 10 boo; 00 when idle
- wave_hands  output  1  hand-wave actuator
- move_jaw  output  1  jaw actuator
- fog_on  output  1  fog machine
- eff_done  output  1  one-cycle pulse when a timed effect finishes
- err_cnt  output  8  saturating count of discarded opcodes

Behaviour:
- Opcode map:
  - 0000 ON, 0001 RESET
  - 0100 GREEN, 0101 PURPLE, 0110 ORANGE
  - 1000 SCREAMING, 1001 CACKLING, 1010 BOO
  - 1100 WAVEHANDS, 1101 MOVEJAW, 1110 FOG
  - All others (0010, 0011, 0111, 1011, 1111) are illegal.
- Reset: state OFF; sys_on=0, color=00, sound_active=0, sound_id=00, wave_hands=0, move_jaw=0, fog_on=0, eff_done=0, err_cnt=0, internal timer=0. Reset overrides any concurrent op and aborts any running effect at that edge.
- States: OFF, IDLE, SOUND, MOVE, FOG. op_ready is combinational from state: 1 in OFF and IDLE, 0 in SOUND/MOVE/FOG. When op_ready=0 the op is not consumed; upstream holds it.
- OFF:
  - Accepted ON: goes to IDLE, sys_on=1 from next cycle.
  - Any other accepted opcode, legal or illegal: discarded, err_cnt+1.
- IDLE, accepted op at edge N (all effects visible from cycle N+1):
  - ON: no-op, not counted.
  - RESET: goes to OFF; sys_on=0, color=00. err_cnt is retained; only rst clears it.
  - Colour: color set to 01/10/11 for GREEN/PURPLE/ORANGE; stays IDLE; colour persists until changed, RESET, or rst.
  - Sound: goes to SOUND; sound_id=op[1:0]; sound_active=1 for cycles N+1..N+SOUND_CYCLES.
  - WAVEHANDS/MOVEJAW: goes to MOVE; the matching actuator is high for cycles N+1..N+MOVE_CYCLES.
  - FOG: goes to FOG; fog_on high for cycles N+1..N+FOG_CYCLES.
  - Illegal: discarded, err_cnt+1, stays IDLE.
- Timed states:
  - Timer loads K-1 on entry and decrements each cycle; at 0 the next edge returns to IDLE.
  - At cycle N+K+1: effect output low, sound_id=00, eff_done=1 for that one cycle, op_ready=1.
  - A new op may be accepted at that same edge; its outputs appear at N+K+2.
  - K=1 gives a single-cycle effect.
- Colour and sys_on are unchanged by timed effects. Only one timed effect at a time.
- err_cnt saturates at 255; further discards leave it at 255.
- op_valid=0: no state change other than timer progress.

Test Plan:
- Reset then op_valid with 0100 in OFF -> op_ready=1, op discarded, err_cnt=1, color=00; then 0000 -> sys_on=1 next cycle.
- In IDLE send 0101, then 0110 back-to-back -> color=10 at N+1, color=11 at N+2, op_ready stays 1.
- In IDLE send 1001 at edge N with SOUND_CYCLES=8 and op_valid held with 1110 -> sound_active=1, sound_id=01 for N+1..N+8; op_ready=0 for those cycles; eff_done pulse and FOG accepted at N+9; fog_on high N+10..N+21.
- Send 1101 with MOVE_CYCLES=4, assert rst=0 at N+2 -> move_jaw high N+1..N+2, all outputs at reset values from N+3, state OFF, err_cnt=0.
- In IDLE send 0011, 1111, then 300 further 0111 -> err_cnt reaches 255 and holds; no output changes.
- In IDLE with color=01 send 0001 -> sys_on=0, color=00 next cycle, err_cnt unchanged; a subsequent 1000 is discarded, err_cnt+1.
